// File: rtl/time_calculate.sv
// Parking-duration calculator: registers (exit - entry) mod 2^WIDTH and a
// rollover flag one cycle after each valid timestamp pair.
module time_calculate #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] time_out,
    input  logic [WIDTH-1:0] time_in,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             wrapped
);

    // Modular difference: the carry out of the subtraction is dropped on purpose,
    // so a counter rollover between entry and exit still yields the true duration.
    function automatic logic [WIDTH-1:0] mod_diff(input logic [WIDTH-1:0] t_exit,
                                                  input logic [WIDTH-1:0] t_entry);
        logic [WIDTH:0] full;
        full = {1'b0, t_exit} - {1'b0, t_entry};
        return full[WIDTH-1:0];
    endfunction

    function automatic logic rolled_over(input logic [WIDTH-1:0] t_exit,
                                         input logic [WIDTH-1:0] t_entry);
        return (t_exit < t_entry);
    endfunction

    logic [WIDTH-1:0] result_p1;
    logic             wrapped_p1;
    logic             vld_p1;

    // Stage p1: output registers; billing sees only flopped values.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1  <= '0;
            wrapped_p1 <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                result_p1  <= mod_diff(time_out, time_in);
                wrapped_p1 <= rolled_over(time_out, time_in);
            end
        end
    end

    assign result    = result_p1;
    assign wrapped   = wrapped_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_time_calculate.sv
// Scoreboard bench for time_calculate: expected duration/rollover pushed at
// drive time, popped and compared when the registered output appears.
module tb_time_calculate;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         wr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] time_out;
    logic [W-1:0] time_in;
    logic [W-1:0] result;
    logic         out_valid;
    logic         wrapped;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    time_calculate #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .time_out (time_out),
        .time_in  (time_in),
        .result   (result),
        .out_valid(out_valid),
        .wrapped  (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int ti, input int to);
        exp_t e;
        e.res = W'((to - ti + 256) % 256);
        e.wr  = (to < ti);
        return e;
    endfunction

    // Drive one cycle of inputs, advance past the edge, then score the outputs.
    task automatic step(input logic r, input logic v, input int ti, input int to);
        exp_t e;
        rst      = r;
        in_valid = v;
        time_in  = W'(ti);
        time_out = W'(to);
        if (!r && v) sb.push_back(model(ti, to));
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            last_exp = '0;
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_result", 32'(result), 0);
            check("rst_wrapped", 32'(wrapped), 0);
        end else if (v) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                last_exp = e;
                check("out_valid", 32'(out_valid), 1);
                check("result", 32'(result), 32'(e.res));
                check("wrapped", 32'(wrapped), 32'(e.wr));
            end
        end else begin
            check("idle_out_valid", 32'(out_valid), 0);
            check("hold_result", 32'(result), 32'(last_exp.res));
            check("hold_wrapped", 32'(wrapped), 32'(last_exp.wr));
        end
    endtask

    int seq_in[8]  = '{0, 0, 0,   0,  1,  1,  1,   1};
    int seq_out[8] = '{0, 16, 128, 87, 87, 86, 76, 232};
    int seq_res[8] = '{0, 16, 128, 87, 86, 85, 75, 231};

    initial begin
        rst = 1'b1; in_valid = 1'b0; time_in = '0; time_out = '0;
        last_exp = '0;
        #2;

        // Reset with a valid pair present: pair must be discarded.
        step(1'b1, 1'b1, 5, 9);

        // Back-to-back pairs with spec-given durations.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, seq_in[i], seq_out[i]);
            check("seq_const", 32'(result), 32'(seq_res[i]));
        end

        // Rollover cases.
        step(1'b0, 1'b1, 200, 10);
        check("roll_66", 32'(result), 66);
        check("roll_66_wr", 32'(wrapped), 1);
        step(1'b0, 1'b1, 255, 0);
        check("roll_1", 32'(result), 1);
        check("roll_1_wr", 32'(wrapped), 1);
        step(1'b0, 1'b1, 255, 255);

        // Hold while in_valid is low and inputs wiggle.
        step(1'b0, 1'b1, 3, 10);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 99);
            check("hold_7", 32'(result), 7);
        end

        // Mid-stream reset, then recovery.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
        step(1'b1, 1'b1, 77, 12);
        step(1'b0, 1'b1, 10, 50);
        check("post_rst_40", 32'(result), 40);

        // Random mix of valid/idle cycles.
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
